// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: processor data-bus slice seen by the memory-mapped UART.
//   Address   : byte address (ALU result)
//   WriteData : store data; [7:0] is the TX byte, [2] clears overrun on STATUS
//   MemWrite  : store strobe, one cycle per sw
//   MemRead   : load strobe
//   ReadData  : status word returned to the load path (0 when not selected)
// master drives the bus (CPU / bench); slave is the UART.
interface uart_tx_mmio_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;

    modport master (
        output Address, WriteData, MemWrite, MemRead,
        input  ReadData
    );
    modport slave (
        input  Address, WriteData, MemWrite, MemRead,
        output ReadData
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter, LSB first.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : uart_tx_mmio_if.slave (Address/WriteData/MemWrite/MemRead/ReadData)
//   Tx         : registered serial line, idles high
//   Busy       : frame on the line or byte queued
// A store to DATA_ADDR queues WriteData[7:0]; STATUS_ADDR reads
// {overrun, full, busy} and a store with WriteData[2]=1 clears overrun.
// Build option: define UART_TX_FIFO_EN for a 4-entry FIFO queue; otherwise
// the queue is a single holding register.
module uart_tx_mmio #(
    parameter logic [31:0] DATA_ADDR    = 32'h1001_0024,
    parameter logic [31:0] STATUS_ADDR  = 32'h1001_0028,
    parameter int          CLKS_PER_BIT = 434
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_mmio_if.slave  bus,
    output logic           Tx,
    output logic           Busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] baudCnt;
    logic [2:0]    bitIdx;
    logic [7:0]    shiftReg;
    logic          overrun;

    logic       empty, full, pop, push, drop, dataWr, ovrClr, baudDone, busy;
    logic [7:0] head;
    logic       unusedWriteBits;

    assign unusedWriteBits = ^bus.WriteData[31:8];

    assign baudDone = (baudCnt == CW'(CLKS_PER_BIT - 1));
    // The queue head leaves either from IDLE or at the end of a stop bit, so
    // consecutive frames follow each other with no idle gap.
    assign pop      = !empty && ((state == IDLE) || ((state == STOP) && baudDone));
    assign dataWr   = bus.MemWrite && (bus.Address == DATA_ADDR);
    // A pop in the same cycle frees a slot, so a write against a full queue
    // is still accepted then.
    assign push     = dataWr && (!full || pop);
    assign drop     = dataWr && full && !pop;
    assign ovrClr   = bus.MemWrite && (bus.Address == STATUS_ADDR) && bus.WriteData[2];

    assign busy     = (state != IDLE) || !empty;
    assign Busy     = busy;
    assign bus.ReadData = (bus.MemRead && (bus.Address == STATUS_ADDR))
                        ? {29'b0, overrun, full, busy} : 32'b0;

`ifdef UART_TX_FIFO_EN
    logic [7:0] fifoMem [4];
    logic [1:0] wrPtr, rdPtr;
    logic [2:0] count;

    assign empty = (count == 3'd0);
    assign full  = (count == 3'd4);
    assign head  = fifoMem[rdPtr];

    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= bus.WriteData[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= 2'd0;
            rdPtr <= 2'd0;
            count <= 3'd0;
        end else begin
            if (push) wrPtr <= wrPtr + 2'd1;
            if (pop)  rdPtr <= rdPtr + 2'd1;
            count <= count + {2'b0, push} - {2'b0, pop};
        end
    end
`else
    logic [7:0] holdReg;
    logic       holdValid;

    assign empty = !holdValid;
    assign full  = holdValid;
    assign head  = holdReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            holdReg   <= 8'h00;
            holdValid <= 1'b0;
        end else begin
            if (push) holdReg <= bus.WriteData[7:0];
            // push wins over pop so a simultaneous pair leaves the slot filled
            if (push)     holdValid <= 1'b1;
            else if (pop) holdValid <= 1'b0;
        end
    end
`endif

    // Drop sets overrun even when a clear arrives in the same cycle.
    always_ff @(posedge clk) begin
        if (reset)       overrun <= 1'b0;
        else if (drop)   overrun <= 1'b1;
        else if (ovrClr) overrun <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            Tx       <= 1'b1;
            baudCnt  <= '0;
            bitIdx   <= 3'd0;
            shiftReg <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    Tx <= 1'b1;
                    if (pop) begin
                        shiftReg <= head;
                        baudCnt  <= '0;
                        state    <= START;
                        Tx       <= 1'b0;
                    end
                end
                START: begin
                    if (baudDone) begin
                        baudCnt <= '0;
                        bitIdx  <= 3'd0;
                        state   <= DATA;
                        Tx      <= shiftReg[0];
                    end else begin
                        baudCnt <= baudCnt + CW'(1);
                    end
                end
                DATA: begin
                    if (baudDone) begin
                        baudCnt <= '0;
                        if (bitIdx == 3'd7) begin
                            state <= STOP;
                            Tx    <= 1'b1;
                        end else begin
                            bitIdx   <= bitIdx + 3'd1;
                            shiftReg <= {1'b0, shiftReg[7:1]};
                            Tx       <= shiftReg[1];
                        end
                    end else begin
                        baudCnt <= baudCnt + CW'(1);
                    end
                end
                STOP: begin
                    if (baudDone) begin
                        baudCnt <= '0;
                        if (pop) begin
                            shiftReg <= head;
                            state    <= START;
                            Tx       <= 1'b0;
                        end else begin
                            state <= IDLE;
                            Tx    <= 1'b1;
                        end
                    end else begin
                        baudCnt <= baudCnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    Tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule
